// File: rtl/ibex_wb_pipe.sv
// rtl/ibex_wb_pipe.sv - writeback stage: ALU/LSU retire, register-file write and WB-to-ID forwarding
module ibex_wb_pipe #(
    parameter logic WbFwd      = 1'b1,
    parameter logic SuppressX0 = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_wb_i,
    input  logic        instr_is_lsu_i,
    input  logic        instr_is_load_i,
    input  logic        rf_we_id_i,
    input  logic [4:0]  rf_waddr_id_i,
    input  logic [31:0] rf_wdata_ex_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] rf_wdata_lsu_i,
    output logic        ready_wb_o,
    output logic        rf_we_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,
    output logic        instr_done_wb_o,
    output logic        lsu_err_wb_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_waddr_o,
    output logic [31:0] fwd_wdata_o
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        ALU_WB   = 2'd1,
        LSU_WAIT = 2'd2
    } wb_state_e;

    wb_state_e   state_q, state_d;
    logic        we_q, is_lsu_q, is_load_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        we_raw;
    logic        accept;

    always_comb begin
        state_d         = state_q;
        ready_wb_o      = 1'b1;
        we_raw          = 1'b0;
        rf_we_wb_o      = 1'b0;
        rf_wdata_wb_o   = 32'd0;
        instr_done_wb_o = 1'b0;
        lsu_err_wb_o    = 1'b0;
        case (state_q)
            EMPTY: begin
                state_d = EMPTY;
            end
            ALU_WB: begin
                we_raw          = we_q;
                rf_wdata_wb_o   = wdata_q;
                instr_done_wb_o = 1'b1;
                state_d         = EMPTY;
            end
            LSU_WAIT: begin
                ready_wb_o = lsu_resp_valid_i;
                if (lsu_resp_valid_i) begin
                    instr_done_wb_o = 1'b1;
                    state_d         = EMPTY;
                    if (lsu_resp_err_i) begin
                        lsu_err_wb_o = 1'b1;
                    end else begin
                        we_raw        = we_q & is_lsu_q & is_load_q;
                        rf_wdata_wb_o = rf_wdata_lsu_i;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (en_wb_i && ready_wb_o) begin
            state_d = instr_is_lsu_i ? LSU_WAIT : ALU_WB;
        end
        rf_we_wb_o = we_raw & ~(SuppressX0 & (waddr_q == 5'd0));
        // Outputs are quiet while reset is held, whatever state is still registered.
        if (rst_i) begin
            ready_wb_o      = 1'b1;
            rf_we_wb_o      = 1'b0;
            rf_wdata_wb_o   = 32'd0;
            instr_done_wb_o = 1'b0;
            lsu_err_wb_o    = 1'b0;
        end
    end

    assign accept        = en_wb_i & ready_wb_o;
    assign rf_waddr_wb_o = rst_i ? 5'd0 : waddr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            is_lsu_q  <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q      <= rf_we_id_i;
                waddr_q   <= rf_waddr_id_i;
                wdata_q   <= rf_wdata_ex_i;
                is_lsu_q  <= instr_is_lsu_i;
                is_load_q <= instr_is_load_i;
            end
        end
    end

    assign fwd_valid_o = WbFwd & rf_we_wb_o;
    assign fwd_waddr_o = WbFwd ? rf_waddr_wb_o : 5'd0;
    assign fwd_wdata_o = WbFwd ? rf_wdata_wb_o : 32'd0;

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// tb/tb_ibex_wb_pipe.sv - self-checking bench for ibex_wb_pipe
module tb_ibex_wb_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_wb_i;
    logic        instr_is_lsu_i;
    logic        instr_is_load_i;
    logic        rf_we_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_ex_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [31:0] rf_wdata_lsu_i;
    logic        ready_wb_o;
    logic        rf_we_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        instr_done_wb_o;
    logic        lsu_err_wb_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_waddr_o;
    logic [31:0] fwd_wdata_o;

    ibex_wb_pipe dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .en_wb_i          (en_wb_i),
        .instr_is_lsu_i   (instr_is_lsu_i),
        .instr_is_load_i  (instr_is_load_i),
        .rf_we_id_i       (rf_we_id_i),
        .rf_waddr_id_i    (rf_waddr_id_i),
        .rf_wdata_ex_i    (rf_wdata_ex_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_err_i   (lsu_resp_err_i),
        .rf_wdata_lsu_i   (rf_wdata_lsu_i),
        .ready_wb_o       (ready_wb_o),
        .rf_we_wb_o       (rf_we_wb_o),
        .rf_waddr_wb_o    (rf_waddr_wb_o),
        .rf_wdata_wb_o    (rf_wdata_wb_o),
        .instr_done_wb_o  (instr_done_wb_o),
        .lsu_err_wb_o     (lsu_err_wb_o),
        .fwd_valid_o      (fwd_valid_o),
        .fwd_waddr_o      (fwd_waddr_o),
        .fwd_wdata_o      (fwd_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst, en, lsu, load, we;
        logic [4:0]  waddr;
        logic [31:0] wex;
        logic        rv, re;
        logic [31:0] ld;
        logic        e_ready, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_chk, e_done, e_err;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        is_lsu;
        logic        is_load;
    } ent_t;

    vec_t vq[$];
    ent_t pend[$];
    ent_t p;
    int   checks = 0;
    int   errors = 0;

    logic        x_ready, x_we, x_done, x_err, x_chk, retire;
    logic [4:0]  x_waddr, last_waddr;
    logic [31:0] x_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic lsu, input logic load, input logic we,
                         input logic [4:0] wa, input logic [31:0] wex, input logic rv, input logic re,
                         input logic [31:0] ld);
        rst_i            = r;
        en_wb_i          = en;
        instr_is_lsu_i   = lsu;
        instr_is_load_i  = load;
        rf_we_id_i       = we;
        rf_waddr_id_i    = wa;
        rf_wdata_ex_i    = wex;
        lsu_resp_valid_i = rv;
        lsu_resp_err_i   = re;
        rf_wdata_lsu_i   = ld;
    endtask

    task automatic compare_all(input logic e_ready, input logic e_we, input logic [4:0] e_waddr,
                               input logic [31:0] e_wdata, input logic e_chk, input logic e_done,
                               input logic e_err);
        check("ready", ready_wb_o, e_ready);
        check("rf_we", rf_we_wb_o, e_we);
        check("rf_waddr", rf_waddr_wb_o, e_waddr);
        check("done", instr_done_wb_o, e_done);
        check("lsu_err", lsu_err_wb_o, e_err);
        check("fwd_valid", fwd_valid_o, e_we);
        check("fwd_waddr", fwd_waddr_o, e_waddr);
        if (e_chk) begin
            check("rf_wdata", rf_wdata_wb_o, e_wdata);
            check("fwd_wdata", fwd_wdata_o, e_wdata);
        end
    endtask

    task automatic add(input logic r, input logic en, input logic lsu, input logic load, input logic we,
                       input logic [4:0] wa, input logic [31:0] wex, input logic rv, input logic re,
                       input logic [31:0] ld, input logic e_ready, input logic e_we, input logic [4:0] e_waddr,
                       input logic [31:0] e_wdata, input logic e_chk, input logic e_done, input logic e_err);
        vq.push_back({r, en, lsu, load, we, wa, wex, rv, re, ld, e_ready, e_we, e_waddr, e_wdata, e_chk, e_done, e_err});
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;

        add(1,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd5, 32'hDEADBEEF, 0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,1,5'd5, 32'hDEADBEEF, 1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd5, 32'h0,        1,0,0);
        add(0,1,1,1,1, 5'd7, 32'h0BADF00D, 0,0, 32'h0,        1,0,5'd5, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        0,0,5'd7, 32'h0,        0,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        0,0,5'd7, 32'h0,        0,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        0,0,5'd7, 32'h0,        0,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        1,0, 32'h12345678, 1,1,5'd7, 32'h12345678, 1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd7, 32'h0,        1,0,0);
        add(0,1,1,0,0, 5'd9, 32'h5,        0,0, 32'h0,        1,0,5'd7, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd3, 32'h33333333, 1,0, 32'hAAAA5555, 1,0,5'd9, 32'hAAAA5555, 1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,1,5'd3, 32'h33333333, 1,1,0);
        add(0,1,1,1,1, 5'd4, 32'h0,        0,0, 32'h0,        1,0,5'd3, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        1,1, 32'hCAFE0000, 1,0,5'd4, 32'h0,        0,1,1);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd4, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd0, 32'h0000FFFF, 0,0, 32'h0,        1,0,5'd4, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd0, 32'h0000FFFF, 1,1,0);
        add(0,1,1,1,1, 5'd6, 32'h0,        0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(1,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        1,0, 32'h77777777, 1,0,5'd0, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd2, 32'h22,       0,0, 32'h0,        1,0,5'd0, 32'h0,        1,0,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        1,0, 32'h999,      1,1,5'd2, 32'h22,       1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd2, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd10, 32'hA,       0,0, 32'h0,        1,0,5'd2, 32'h0,        1,0,0);
        add(0,1,0,0,1, 5'd11, 32'hB,       0,0, 32'h0,        1,1,5'd10, 32'hA,       1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,1,5'd11, 32'hB,       1,1,0);
        add(0,0,0,0,0, 5'd0, 32'h0,        0,0, 32'h0,        1,0,5'd11, 32'h0,       1,0,0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].en, vq[i].lsu, vq[i].load, vq[i].we, vq[i].waddr, vq[i].wex,
                  vq[i].rv, vq[i].re, vq[i].ld);
            @(negedge clk_i);
            compare_all(vq[i].e_ready, vq[i].e_we, vq[i].e_waddr, vq[i].e_wdata, vq[i].e_chk,
                        vq[i].e_done, vq[i].e_err);
            @(posedge clk_i);
            #1;
        end

        // A load may wait indefinitely for its response without retiring.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h1, 1'b0, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            check("wait_ready", ready_wb_o, 1'b0);
            check("wait_done", instr_done_wb_o, 1'b0);
            check("wait_we", rf_we_wb_o, 1'b0);
            @(posedge clk_i);
            #1;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h5A5A5A5A);
        @(negedge clk_i);
        compare_all(1'b1, 1'b1, 5'd8, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0);
        @(posedge clk_i);
        #1;

        last_waddr = 5'd0;
        pend.delete();
        for (int i = 0; i < 3000; i++) begin
            drive((i == 0) || ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), $urandom);
            retire  = 1'b0;
            x_ready = 1'b1;
            x_we    = 1'b0;
            x_wdata = 32'd0;
            x_chk   = 1'b1;
            x_done  = 1'b0;
            x_err   = 1'b0;
            x_waddr = rst_i ? 5'd0 : last_waddr;
            if (!rst_i && pend.size() != 0) begin
                p = pend[0];
                if (!p.is_lsu) begin
                    retire  = 1'b1;
                    x_we    = p.we && (p.waddr != 5'd0);
                    x_wdata = p.data;
                    x_done  = 1'b1;
                end else if (lsu_resp_valid_i) begin
                    retire = 1'b1;
                    x_done = 1'b1;
                    if (lsu_resp_err_i) begin
                        x_err = 1'b1;
                        x_chk = 1'b0;
                    end else begin
                        x_we    = p.we && p.is_load && (p.waddr != 5'd0);
                        x_wdata = rf_wdata_lsu_i;
                    end
                end else begin
                    x_ready = 1'b0;
                    x_chk   = 1'b0;
                end
            end
            @(negedge clk_i);
            compare_all(x_ready, x_we, x_waddr, x_wdata, x_chk, x_done, x_err);
            if (rst_i) begin
                pend.delete();
                last_waddr = 5'd0;
            end else begin
                if (retire) void'(pend.pop_front());
                if (en_wb_i && x_ready) begin
                    pend.push_back({rf_we_id_i, rf_waddr_id_i, rf_wdata_ex_i, instr_is_lsu_i, instr_is_load_i});
                    last_waddr = rf_waddr_id_i;
                end
            end
            @(posedge clk_i);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
